// File: rtl/scs8hd_tmr_pkg.sv
// Shared types and helpers for the TMR scrub controller: state encoding, lane indices,
// and the bitwise majority vote and lane-mismatch functions.
package scs8hd_tmr_pkg;

    // Widest word the vote helpers handle; callers zero-extend narrower words.
    localparam int MAX_W     = 64;
    localparam int NUM_LANES = 3;
    localparam int LANE0     = 0;
    localparam int LANE1     = 1;
    localparam int LANE2     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CORRECT = 2'd2
    } tmr_state_e;

    function automatic logic [MAX_W-1:0] maj3_vec(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input logic [MAX_W-1:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    function automatic logic lane_mismatch(input logic [MAX_W-1:0] copy,
                                           input logic [MAX_W-1:0] vote);
        return |(copy ^ vote);
    endfunction

endpackage

// File: rtl/scs8hd_tmr_vote.sv
// Combinational bitwise 2-of-3 vote over three copies plus per-lane mismatch mask.
// Zero latency, no flow control.
module scs8hd_tmr_vote
    import scs8hd_tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     copy0_i,
    input  logic [WIDTH-1:0]     copy1_i,
    input  logic [WIDTH-1:0]     copy2_i,
    output logic [WIDTH-1:0]     vote_o,
    output logic [NUM_LANES-1:0] mismatch_o
);

    logic [MAX_W-1:0] c0_ext;
    logic [MAX_W-1:0] c1_ext;
    logic [MAX_W-1:0] c2_ext;
    logic [MAX_W-1:0] vote_ext;

    assign c0_ext   = MAX_W'(copy0_i);
    assign c1_ext   = MAX_W'(copy1_i);
    assign c2_ext   = MAX_W'(copy2_i);
    assign vote_ext = maj3_vec(c0_ext, c1_ext, c2_ext);
    assign vote_o   = vote_ext[WIDTH-1:0];

    assign mismatch_o[LANE0] = lane_mismatch(c0_ext, vote_ext);
    assign mismatch_o[LANE1] = lane_mismatch(c1_ext, vote_ext);
    assign mismatch_o[LANE2] = lane_mismatch(c2_ext, vote_ext);

endmodule

// File: rtl/scs8hd_tmr_scrub_ctrl.sv
// TMR register with periodic scrub; rd_data is the combinational vote, writes land next edge and
// stall (wr_ready low) during CHECK/CORRECT. Optional fault-injection port under TMR_FAULT_INJ_EN.
module scs8hd_tmr_scrub_ctrl
    import scs8hd_tmr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SCRUB_PERIOD = 16,
    parameter int CNT_W        = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 wr_valid,
    input  logic [WIDTH-1:0]     wr_data,
`ifdef TMR_FAULT_INJ_EN
    input  logic                 inj_valid,
    input  logic [1:0]           inj_lane,
    input  logic [WIDTH-1:0]     inj_mask,
`endif
    output logic                 wr_ready,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 scrub_busy,
    output logic                 err_valid,
    output logic [NUM_LANES-1:0] err_lane,
    output logic                 err_multi,
    output logic [CNT_W-1:0]     err_count
);

    localparam int TMR_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);

    tmr_state_e           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]     copy_q [NUM_LANES];
    logic [WIDTH-1:0]     copy_d [NUM_LANES];
    logic [WIDTH-1:0]     vote_q, vote_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_LANES-1:0] err_lane_q, err_lane_d;
    logic                 err_multi_q, err_multi_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;

    logic [WIDTH-1:0]     vote;
    logic [NUM_LANES-1:0] mismatch;
    logic                 wr_fire;

    scs8hd_tmr_vote #(.WIDTH(WIDTH)) u_vote (
        .copy0_i    (copy_q[LANE0]),
        .copy1_i    (copy_q[LANE1]),
        .copy2_i    (copy_q[LANE2]),
        .vote_o     (vote),
        .mismatch_o (mismatch)
    );

    assign wr_ready   = (state_q == IDLE);
    assign wr_fire    = wr_valid && wr_ready;
    assign rd_data    = vote;
    assign scrub_busy = (state_q == CHECK) || (state_q == CORRECT);
    assign err_valid  = (state_q == CORRECT);
    assign err_lane   = err_lane_q;
    assign err_multi  = err_multi_q;
    assign err_count  = err_count_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        copy_d      = copy_q;
        vote_d      = vote_q;
        mask_d      = mask_q;
        err_lane_d  = err_lane_q;
        err_multi_d = err_multi_q;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    for (int k = 0; k < NUM_LANES; k++) copy_d[k] = wr_data;
                    timer_d = '0;
                end else begin
`ifdef TMR_FAULT_INJ_EN
                    // Lane index 3 matches no copy and is dropped.
                    for (int k = 0; k < NUM_LANES; k++) begin
                        if (inj_valid && (inj_lane == 2'(k))) copy_d[k] = copy_q[k] ^ inj_mask;
                    end
`endif
                    if (timer_q == TMR_LAST) begin
                        timer_d = '0;
                        state_d = CHECK;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            CHECK: begin
                vote_d  = vote;
                mask_d  = mismatch;
                state_d = (mismatch != '0) ? CORRECT : IDLE;
            end
            CORRECT: begin
                for (int k = 0; k < NUM_LANES; k++) copy_d[k] = vote_q;
                err_lane_d  = mask_q;
                err_multi_d = &mask_q;
                if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            for (int k = 0; k < NUM_LANES; k++) copy_q[k] <= '0;
            vote_q      <= '0;
            mask_q      <= '0;
            err_lane_q  <= '0;
            err_multi_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            copy_q      <= copy_d;
            vote_q      <= vote_d;
            mask_q      <= mask_d;
            err_lane_q  <= err_lane_d;
            err_multi_q <= err_multi_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
